// File: rtl/alu_mseq.sv
// Handshaked integer ALU: single-cycle RV base ops plus iterative unsigned
// MUL/MULHU/DIVU/REMU (one bit per cycle), one operation in flight at a time.
module alu_mseq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            err,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] rd_q;
  logic            err_q;
  logic            valid_q;
  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q;  // product high half / partial remainder
  logic [XLEN-1:0] lo_q;   // multiplier-product low half / dividend-quotient
  logic [XLEN-1:0] b_q;    // multiplicand / divisor
  logic            div_q;
  logic            hi_q;   // result comes from acc (MULHU, REMU)

  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic            base_err;
  logic            m_start;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic            div_ge;
  logic [XLEN-1:0] step_acc;
  logic [XLEN-1:0] step_lo;
  logic [XLEN-1:0] fin_res;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign rd        = rd_q;
  assign err       = err_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign shamt     = rs2[SHW-1:0];

  // Decode: single-cycle result, or request to start an iterative op
  always_comb begin
    base_res = '0;
    base_err = 1'b0;
    m_start  = 1'b0;
    if (!op[4]) begin
      case (op[3:0])
        4'b0000: base_res = rs1 + rs2;
        4'b1000: base_res = rs1 - rs2;
        4'b0001: base_res = rs1 << shamt;
        4'b0010: base_res = XLEN'($signed(rs1) < $signed(rs2));
        4'b0011: base_res = XLEN'(rs1 < rs2);
        4'b0100: base_res = rs1 ^ rs2;
        4'b0101: base_res = rs1 >> shamt;
        4'b1101: base_res = XLEN'($signed(rs1) >>> shamt);
        4'b0110: base_res = rs1 | rs2;
        4'b0111: base_res = rs1 & rs2;
        default: base_err = 1'b1;
      endcase
    end else begin
      case (op[3:0])
        4'b0000, 4'b0011: m_start = 1'b1;
        4'b0101: begin
          if (rs2 == '0) base_res = '1;
          else           m_start  = 1'b1;
        end
        4'b0111: begin
          if (rs2 == '0) base_res = rs1;
          else           m_start  = 1'b1;
        end
        default: base_err = 1'b1;
      endcase
    end
  end

  // One shift-add or restoring shift-subtract step
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_q, lo_q[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, b_q});
    step_acc = mul_sum[XLEN:1];
    step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    if (div_q) begin
      step_acc = div_ge ? XLEN'(div_sh - {1'b0, b_q}) : div_sh[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], div_ge};
    end
    fin_res = hi_q ? step_acc : step_lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      hi_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (m_start) begin
              state_q <= BUSY;
              busy_q  <= 1'b1;
              valid_q <= 1'b0;
              err_q   <= 1'b0;
              cnt_q   <= CW'(XLEN);
              acc_q   <= '0;
              lo_q    <= rs1;
              b_q     <= rs2;
              div_q   <= op[2];
              hi_q    <= op[1];
            end else begin
              state_q <= DONE;
              valid_q <= 1'b1;
              rd_q    <= base_res;
              err_q   <= base_err;
            end
          end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        BUSY: begin
          acc_q <= step_acc;
          lo_q  <= step_lo;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            rd_q    <= fin_res;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_mseq.md
Name: alu_mseq

Overview:
- Parametrised, handshaked successor to the single-cycle registered integer ALU.
- Executes the RV base ALU ops in one cycle. Adds an unsigned multiply/divide subset (MUL, MULHU, DIVU, REMU) as iterative one-bit-per-cycle sequential units.
- Sits between the issue stage and writeback, with valid/ready on both sides.
- Only one operation is in flight at a time.

Parameters:
- XLEN, 32, operand/result width. Must be a power of two, 8..64.
- SHW, $clog2(XLEN), shift-amount width. Localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block accepts a request this cycle.
- op  in  5  {m_ext, funct7[5], funct3}.
- rs1  in  XLEN  operand A.
- rs2  in  XLEN  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- rd  out  XLEN  result.
- err  out  1  illegal op; qualified by out_valid.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset: state=IDLE; rd=0, out_valid=0, err=0, busy=0; iteration counter and partial registers cleared.
  - Asynchronous reset mid-operation aborts it. No result is produced for the aborted request.
- Accept: a request is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue.
  - rs1, rs2 and op are captured on accept. Inputs are don't-care afterwards.
- Base ops (op[4]=0):
  - 00000 ADD, 01000 SUB, 00001 SLL, 00010 SLT, 00011 SLTU, 00100 XOR, 00101 SRL, 01101 SRA, 00110 OR, 00111 AND.
  - Shifts use rs2[SHW-1:0] only. SLT/SLTU return 0 or 1, zero-extended.
  - ADD/SUB wrap modulo 2^XLEN.
  - Latency 1: accept in cycle T gives out_valid=1 in T+1 (state DONE).
- M ops (op[4]=1):
  - 10000 MUL returns the low XLEN bits of rs1*rs2 (unsigned).
  - 10011 MULHU returns the high XLEN bits.
  - 10101 DIVU returns floor(rs1/rs2).
  - 10111 REMU returns rs1 mod rs2.
  - Sequence: state IDLE->BUSY; counter loaded with XLEN; one shift-add (MUL) or restoring shift-subtract (DIV) step per BUSY cycle.
  - When the counter reaches 0 the block moves to DONE. Accept in T gives out_valid in T+XLEN+1.
  - busy=1 exactly while in BUSY.
- Divide by zero (DIVU/REMU with rs2==0):
  - No BUSY phase; latency 1.
  - DIVU returns all-ones; REMU returns rs1; err=0.
- Illegal op (any other op code with op[4]=1, or a base code not listed): latency 1, rd=0, err=1.
- DONE:
  - rd and err are held stable while out_valid && !out_ready.
  - out_ready=1 with no new accept gives DONE->IDLE and out_valid=0 next cycle.
  - out_ready=1 with a new accept in the same cycle loads the new op, following the same IDLE transition rules.
- States: IDLE, BUSY, DONE. No other states exist. Any unreachable encoding returns to IDLE.
- out_ready is ignored outside DONE. in_valid is ignored in BUSY (in_ready=0).

Test Plan:
- Reset released; ADD rs1=0x7FFFFFFF, rs2=1, out_ready=1 -> out_valid 1 cycle after accept, rd=0x80000000, err=0.
- SRA rs1=0x80000000, rs2=0x24 (shamt=4) -> rd=0xF8000000. SLT rs1=0xFFFFFFFF, rs2=0 -> rd=1. SLTU with the same operands -> rd=0.
- MUL rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> busy 32 cycles, out_valid at T+33, rd=0x00000001. MULHU with the same operands -> rd=0xFFFFFFFE.
- DIVU 100/7 -> rd=14 at T+33. REMU 100/7 -> rd=2. DIVU x/0 -> rd=0xFFFFFFFF at T+1. REMU 0x1234/0 -> rd=0x1234 at T+1.
- Backpressure: out_ready=0 for 5 cycles after the ADD result -> rd and out_valid held, in_ready=0. Then out_ready=1 together with a new in_valid -> next result the following cycle, no bubble.
- Assert reset 10 cycles into a DIVU -> all outputs 0 immediately. After release, a new ADD 3+4 -> rd=7. op=10001 -> rd=0, err=1. Repeat the ALU checks with XLEN=8: MUL 0xFF*0xFF -> rd=0x01 at T+9.
